// File: rtl/vending_pkg.sv
// Shared types and constants for the vending machine controller.
package vending_pkg;

   // Controller phases
   typedef enum logic [1:0] {
      IDLE,
      DISPENSE,
      CHANGE
   } vend_state_t;

   // Width of the credit register and the credit display bus
   localparam int CREDIT_W = 8;

   // Bit positions in the event vector; a higher index wins over a lower one
   localparam int EV_COIN1  = 0;
   localparam int EV_COIN2  = 1;
   localparam int EV_SELECT = 2;
   localparam int EV_CANCEL = 3;
   localparam int EV_N      = 4;

   // Keep only the highest-priority event of a cycle, as a one-hot vector
   function automatic logic [EV_N-1:0] pick_event(input logic [EV_N-1:0] ev);
      logic [EV_N-1:0] win;
      win = '0;
      if (ev[EV_CANCEL])
         win[EV_CANCEL] = 1'b1;
      else if (ev[EV_SELECT])
         win[EV_SELECT] = 1'b1;
      else if (ev[EV_COIN2])
         win[EV_COIN2] = 1'b1;
      else if (ev[EV_COIN1])
         win[EV_COIN1] = 1'b1;
      return win;
   endfunction

endpackage

// File: rtl/switch_debounce.sv
// Synchronizes one raw panel switch, debounces it and flags press events.
module switch_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk_50,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchronizer, since the raw switch is asynchronous to clk_50
   always_ff @(posedge clk_50) begin
      if (rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   // Flip the stable level only after the input has disagreed with it for a full run of cycles
   always_ff @(posedge clk_50) begin
      if (rst) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (sync_b == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt    <= '0;
         stable <= ~stable;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Register the level one more stage so rise and level change together on a press
   always_ff @(posedge clk_50) begin
      if (rst) begin
         level <= 1'b0;
         rise  <= 1'b0;
      end else begin
         level <= stable;
         rise  <= stable & ~level;
      end
   end

endmodule

// File: rtl/vending_ctrl.sv
// Vending machine controller: debounced panel inputs, credit keeping, dispense/change sequencing and LEDs.
module vending_ctrl
   import vending_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int PRICE           = 100,
   parameter int COIN1_VAL       = 25,
   parameter int COIN2_VAL       = 50,
   parameter int MAX_CREDIT      = 200
) (
   input  logic                clk_50,
   input  logic                rst,
   input  logic                sw1,
   input  logic                sw2,
   input  logic                sw3,
   input  logic                sw4,
   output logic                led1,
   output logic                led2,
   output logic                led3,
   output logic                led4,
   output logic [CREDIT_W-1:0] credit
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0]   HOLD_FULL = HOLD_W'(HOLD_CYCLES);
   localparam logic [CREDIT_W:0]   COIN1_9   = (CREDIT_W+1)'(COIN1_VAL);
   localparam logic [CREDIT_W:0]   COIN2_9   = (CREDIT_W+1)'(COIN2_VAL);
   localparam logic [CREDIT_W:0]   MAX_9     = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] PRICE_8   = CREDIT_W'(PRICE);

   logic [EV_N-1:0]     sw_raw;
   logic [EV_N-1:0]     sw_level;
   logic [EV_N-1:0]     sw_rise;
   logic [EV_N-1:0]     ev;

   vend_state_t         state;
   vend_state_t         state_next;
   logic [CREDIT_W-1:0] credit_next;
   logic [CREDIT_W:0]   sum1;
   logic [CREDIT_W:0]   sum2;
   logic [HOLD_W-1:0]   hold;
   logic [HOLD_W-1:0]   hold_next;
   logic [HOLD_W-1:0]   reject;
   logic [HOLD_W-1:0]   reject_next;

   assign sw_raw[EV_COIN1]  = sw1;
   assign sw_raw[EV_COIN2]  = sw2;
   assign sw_raw[EV_SELECT] = sw3;
   assign sw_raw[EV_CANCEL] = sw4;

   genvar i;
   generate
      for (i = 0; i < EV_N; i++) begin : g_sw
         switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk_50 (clk_50),
            .rst    (rst),
            .raw    (sw_raw[i]),
            .level  (sw_level[i]),
            .rise   (sw_rise[i])
         );
      end
   endgenerate

   // Next-state logic: one prioritized event acted on in IDLE, fixed-length DISPENSE and CHANGE phases
   always_comb begin
      state_next  = state;
      credit_next = credit;
      hold_next   = hold;
      reject_next = (reject != '0) ? reject - HOLD_W'(1) : '0;
      ev          = pick_event(sw_rise & sw_level);
      sum1        = {1'b0, credit} + COIN1_9;
      sum2        = {1'b0, credit} + COIN2_9;

      case (state)
         IDLE: begin
            if (ev[EV_CANCEL]) begin
               if (credit != '0) begin
                  state_next = CHANGE;
                  hold_next  = HOLD_LAST;
               end
            end else if (ev[EV_SELECT]) begin
               if (credit >= PRICE_8) begin
                  credit_next = credit - PRICE_8;
                  state_next  = DISPENSE;
                  hold_next   = HOLD_LAST;
               end
            end else if (ev[EV_COIN2]) begin
               if (sum2 <= MAX_9)
                  credit_next = sum2[CREDIT_W-1:0];
               else
                  reject_next = HOLD_FULL;
            end else if (ev[EV_COIN1]) begin
               if (sum1 <= MAX_9)
                  credit_next = sum1[CREDIT_W-1:0];
               else
                  reject_next = HOLD_FULL;
            end
         end
         DISPENSE: begin
            if (hold == '0) begin
               if (credit != '0) begin
                  state_next = CHANGE;
                  hold_next  = HOLD_LAST;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               hold_next = hold - HOLD_W'(1);
            end
         end
         CHANGE: begin
            if (hold == '0) begin
               state_next  = IDLE;
               credit_next = '0;
            end else begin
               hold_next = hold - HOLD_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, credit, timers and LEDs; LEDs come from next values so they move with the state
   always_ff @(posedge clk_50) begin
      if (rst) begin
         state  <= IDLE;
         credit <= '0;
         hold   <= '0;
         reject <= '0;
         led1   <= 1'b0;
         led2   <= 1'b0;
         led3   <= 1'b0;
         led4   <= 1'b0;
      end else begin
         state  <= state_next;
         credit <= credit_next;
         hold   <= hold_next;
         reject <= reject_next;
         led1   <= (state_next == IDLE) && (credit_next >= PRICE_8);
         led2   <= (state_next == DISPENSE);
         led3   <= (state_next == CHANGE);
         led4   <= (reject_next != '0);
      end
   end

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed self-checking bench for vending_ctrl with short debounce and hold times.
module tb_vending_ctrl;

   logic       clk_50;
   logic       rst;
   logic [3:0] sw_drv;
   logic       led1;
   logic       led2;
   logic       led3;
   logic       led4;
   logic [7:0] credit;

   int total_checks;
   int bad_checks;

   vending_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (8),
      .PRICE           (100),
      .COIN1_VAL       (25),
      .COIN2_VAL       (50),
      .MAX_CREDIT      (200)
   ) dut (
      .clk_50 (clk_50),
      .rst    (rst),
      .sw1    (sw_drv[0]),
      .sw2    (sw_drv[1]),
      .sw3    (sw_drv[2]),
      .sw4    (sw_drv[3]),
      .led1   (led1),
      .led2   (led2),
      .led3   (led3),
      .led4   (led4),
      .credit (credit)
   );

   // 50 MHz clock
   initial begin
      clk_50 = 1'b0;
      forever #10 clk_50 = ~clk_50;
   end

   // Guard against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int obs, input int exp);
      total_checks++;
      if (obs !== exp) begin
         bad_checks++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_50);
      #1;
   endtask

   task automatic settle(input int n);
      repeat (n) step();
   endtask

   // Hold one switch high for len cycles, then release it
   task automatic applyStimulus(input int idx, input int len);
      sw_drv[idx] = 1'b1;
      settle(len);
      sw_drv[idx] = 1'b0;
   endtask

   // Press a switch long enough to register and let the release debounce out
   task automatic press(input int idx);
      applyStimulus(idx, 6);
      settle(10);
   endtask

   // Count consecutive cycles a LED stays high, starting from the current cycle
   task automatic countHigh(input int which, output int n);
      logic v;
      n = 0;
      v = (which == 2) ? led2 : (which == 3) ? led3 : led4;
      while (v && n < 40) begin
         n++;
         step();
         v = (which == 2) ? led2 : (which == 3) ? led3 : led4;
      end
   endtask

   initial begin
      int n;
      total_checks = 0;
      bad_checks   = 0;
      rst    = 1'b1;
      sw_drv = 4'b0000;
      settle(3);
      checkOutput("reset_credit", credit, 0);
      checkOutput("reset_leds", {led4, led3, led2, led1}, 0);
      rst = 1'b0;
      step();

      // Exact purchase: 50 + 50, select, no change phase
      press(1);
      checkOutput("t1_credit50", credit, 50);
      checkOutput("t1_led1_low", led1, 0);
      press(1);
      checkOutput("t1_credit100", credit, 100);
      checkOutput("t1_led1_ready", led1, 1);
      sw_drv[2] = 1'b1;
      settle(7);
      checkOutput("t1_sel_not_yet", led2, 0);
      step();
      checkOutput("t1_led2_rise", led2, 1);
      checkOutput("t1_led1_fall", led1, 0);
      checkOutput("t1_credit0", credit, 0);
      sw_drv[2] = 1'b0;
      countHigh(2, n);
      checkOutput("t1_dispense_len", n, 8);
      checkOutput("t1_no_change", led3, 0);
      settle(10);
      checkOutput("t1_idle_leds", {led4, led3, led2, led1}, 0);

      // Overpay: 50 + 25 + 50, select, dispense then change
      press(1);
      press(0);
      checkOutput("t2_credit75", credit, 75);
      press(1);
      checkOutput("t2_credit125", credit, 125);
      sw_drv[2] = 1'b1;
      settle(8);
      sw_drv[2] = 1'b0;
      checkOutput("t2_led2_rise", led2, 1);
      checkOutput("t2_credit25", credit, 25);
      countHigh(2, n);
      checkOutput("t2_dispense_len", n, 8);
      checkOutput("t2_led3_backtoback", led3, 1);
      checkOutput("t2_credit_in_change", credit, 25);
      countHigh(3, n);
      checkOutput("t2_change_len", n, 8);
      checkOutput("t2_credit_cleared", credit, 0);
      settle(6);

      // Glitch rejection: 3-cycle pulse ignored, 5-cycle pulse accepted
      applyStimulus(0, 3);
      settle(10);
      checkOutput("t3_glitch_ignored", credit, 0);
      applyStimulus(0, 5);
      settle(2);
      checkOutput("t3_before_accept", credit, 0);
      step();
      checkOutput("t3_accept", credit, 25);
      settle(10);

      // Overflow: fill to 200, then two rejects four cycles apart
      press(1);
      press(1);
      press(1);
      checkOutput("t4_credit175", credit, 175);
      press(0);
      checkOutput("t4_credit200", credit, 200);
      sw_drv[0] = 1'b1;
      settle(4);
      sw_drv[1] = 1'b1;
      settle(3);
      checkOutput("t4_led4_not_yet", led4, 0);
      step();
      checkOutput("t4_led4_rise", led4, 1);
      countHigh(4, n);
      sw_drv[0] = 1'b0;
      sw_drv[1] = 1'b0;
      checkOutput("t4_reject_len", n, 12);
      checkOutput("t4_credit_kept", credit, 200);
      settle(10);

      // Cancel from 200 refunds everything, then rebuild 100
      press(3);
      settle(10);
      checkOutput("t5_cancel_refund", credit, 0);
      press(1);
      press(1);
      checkOutput("t5_credit100", credit, 100);

      // Cancel and select together: refund wins
      sw_drv[2] = 1'b1;
      sw_drv[3] = 1'b1;
      settle(8);
      sw_drv[2] = 1'b0;
      sw_drv[3] = 1'b0;
      checkOutput("t5_led3_refund", led3, 1);
      checkOutput("t5_no_dispense", led2, 0);
      checkOutput("t5_credit_held", credit, 100);
      countHigh(3, n);
      checkOutput("t5_change_len", n, 8);
      checkOutput("t5_credit0", credit, 0);
      settle(10);
      checkOutput("t5_still_no_dispense", {led4, led3, led2, led1}, 0);

      // Reset in the 3rd cycle of DISPENSE, with coin2 held through reset
      press(1);
      press(1);
      sw_drv[2] = 1'b1;
      settle(8);
      sw_drv[2] = 1'b0;
      checkOutput("t6_dispense", led2, 1);
      settle(2);
      rst       = 1'b1;
      sw_drv[1] = 1'b1;
      step();
      checkOutput("t6_reset_leds", {led4, led3, led2, led1}, 0);
      checkOutput("t6_reset_credit", credit, 0);
      settle(2);
      rst = 1'b0;
      settle(7);
      checkOutput("t6_held_not_yet", credit, 0);
      step();
      checkOutput("t6_held_once", credit, 50);
      settle(20);
      checkOutput("t6_held_no_repeat", credit, 50);
      sw_drv[1] = 1'b0;
      settle(12);
      checkOutput("t6_final_credit", credit, 50);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
